// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for a register-file/ALU datapath: runs one command
// for cmd_rep+1 iterations, optionally writing back each result, then holds a response.
module alu_seq_ctrl #(
    parameter int CNT_W      = 4,
    parameter bit STOP_ON_OF = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [4:0]       cmd_ra,
    input  logic [4:0]       cmd_rb,
    input  logic [4:0]       cmd_rw,
    input  logic             cmd_wb,
    input  logic [CNT_W-1:0] cmd_rep,

    output logic [4:0]       dp_addr_a,
    output logic [4:0]       dp_addr_b,
    output logic [4:0]       dp_addr_w,
    output logic [2:0]       dp_alu_op,
    output logic             dp_write,
    input  logic [31:0]      dp_f,
    input  logic             dp_zf,
    input  logic             dp_of,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_zf,
    output logic             rsp_of,
    output logic [CNT_W:0]   rsp_iters,

    output logic             busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       state;
    logic [2:0]       op_q;
    logic [4:0]       ra_q;
    logic [4:0]       rb_q;
    logic [4:0]       rw_q;
    logic             wb_q;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W:0]   iters;
    logic [31:0]      f_q;
    logic             zf_q;
    logic             of_sticky;
    logic             of_last;

    logic             of_now;
    logic             loop_end;
    logic             active;

    // The overflow that ends the loop is the one from the iteration just
    // executed: live from the datapath in EXEC, the captured copy in WRITE.
    assign of_now   = (state == S_EXEC) ? dp_of : of_last;
    assign loop_end = (remaining == '0) || (STOP_ON_OF && of_now);

    // NOTE: every register here is sequential state, so all of it is assigned
    // with non-blocking <= and cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rw_q      <= '0;
            wb_q      <= 1'b0;
            remaining <= '0;
            iters     <= '0;
            f_q       <= '0;
            zf_q      <= 1'b0;
            of_sticky <= 1'b0;
            of_last   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        ra_q      <= cmd_ra;
                        rb_q      <= cmd_rb;
                        rw_q      <= cmd_rw;
                        wb_q      <= cmd_wb;
                        remaining <= cmd_rep;
                        iters     <= '0;
                        of_sticky <= 1'b0;
                        of_last   <= 1'b0;
                        state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    f_q       <= dp_f;
                    zf_q      <= dp_zf;
                    of_sticky <= of_sticky | dp_of;
                    of_last   <= dp_of;
                    iters     <= iters + (CNT_W+1)'(1);
                    if (wb_q) begin
                        state <= S_WRITE;
                    end else if (loop_end) begin
                        state <= S_RESP;
                    end else begin
                        remaining <= remaining - CNT_W'(1);
                        state     <= S_EXEC;
                    end
                end
                S_WRITE: begin
                    if (loop_end) begin
                        state <= S_RESP;
                    end else begin
                        remaining <= remaining - CNT_W'(1);
                        state     <= S_EXEC;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Gating with rst_n keeps cmd_ready low while reset is held even though
    // the state register already reads IDLE.
    assign cmd_ready = rst_n && (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign active    = (state == S_EXEC) || (state == S_WRITE);

    assign dp_addr_a = active ? ra_q : 5'd0;
    assign dp_addr_b = active ? rb_q : 5'd0;
    assign dp_addr_w = active ? rw_q : 5'd0;
    assign dp_alu_op = active ? op_q : 3'd0;
    assign dp_write  = (state == S_WRITE);

    assign rsp_valid = (state == S_RESP);
    assign rsp_data  = f_q;
    assign rsp_zf    = zf_q;
    assign rsp_of    = of_sticky;
    assign rsp_iters = iters;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: a small register file and ALU stand in
// for the datapath so write-back and loop behaviour can be observed end to end.
module tb_alu_seq_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [4:0]       cmd_ra, cmd_rb, cmd_rw;
    logic             cmd_wb;
    logic [CNT_W-1:0] cmd_rep;
    logic [4:0]       dp_addr_a, dp_addr_b, dp_addr_w;
    logic [2:0]       dp_alu_op;
    logic             dp_write;
    logic [31:0]      dp_f;
    logic             dp_zf, dp_of;
    logic             rsp_valid, rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_zf, rsp_of;
    logic [CNT_W:0]   rsp_iters;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.CNT_W(CNT_W), .STOP_ON_OF(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rw(cmd_rw), .cmd_wb(cmd_wb), .cmd_rep(cmd_rep),
        .dp_addr_a(dp_addr_a), .dp_addr_b(dp_addr_b), .dp_addr_w(dp_addr_w),
        .dp_alu_op(dp_alu_op), .dp_write(dp_write), .dp_f(dp_f), .dp_zf(dp_zf), .dp_of(dp_of),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zf(rsp_zf), .rsp_of(rsp_of), .rsp_iters(rsp_iters), .busy(busy)
    );

    // Register file with a bench-side preload port and write tracking.
    logic [31:0] rf [32];
    logic        tb_we = 1'b0;
    logic [4:0]  tb_wa = '0;
    logic [31:0] tb_wd = '0;
    int          wr_count = 0;
    logic [4:0]  last_wa = '0;

    always @(posedge clk) begin
        if (tb_we) begin
            rf[tb_wa] <= tb_wd;
        end else if (dp_write) begin
            rf[dp_addr_w] <= dp_f;
            wr_count      <= wr_count + 1;
            last_wa       <= dp_addr_w;
        end
    end

    // ALU: 3 = inc, 4 = add, 5 = sub, anything else passes A through.
    logic [31:0] alu_a, alu_b, alu_f;
    logic        alu_of;
    always_comb begin
        alu_a  = rf[dp_addr_a];
        alu_b  = rf[dp_addr_b];
        alu_f  = alu_a;
        alu_of = 1'b0;
        case (dp_alu_op)
            3'd3: begin
                alu_f  = alu_a + 32'd1;
                alu_of = (alu_a == 32'h7fff_ffff);
            end
            3'd4: begin
                alu_f  = alu_a + alu_b;
                alu_of = (alu_a[31] == alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            3'd5: begin
                alu_f  = alu_a - alu_b;
                alu_of = (alu_a[31] != alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            default: ;
        endcase
    end
    assign dp_f  = alu_f;
    assign dp_zf = (alu_f == 32'd0);
    assign dp_of = alu_of;

    task automatic preload(input logic [4:0] addr, input logic [31:0] data);
        tb_we = 1'b1;
        tb_wa = addr;
        tb_wd = data;
        @(posedge clk);
        #1;
        tb_we = 1'b0;
    endtask

    task automatic drive_cmd(input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb,
                             input logic [4:0] rw, input logic wb, input logic [CNT_W-1:0] rep);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ra    = ra;
        cmd_rb    = rb;
        cmd_rw    = rw;
        cmd_wb    = wb;
        cmd_rep   = rep;
    endtask

    // Counts posedges from the accepting edge until rsp_valid, bounded.
    task automatic wait_resp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL resp_timeout rsp_valid=%b after %0d cycles, want 1", rsp_valid, lat);
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb,
                           input logic [4:0] rw, input logic wb, input logic [CNT_W-1:0] rep,
                           output int lat, output int wrs);
        int w0;
        w0 = wr_count;
        drive_cmd(op, ra, rb, rw, wb, rep);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_resp(lat);
        wrs = wr_count - w0;
    endtask

    task automatic finish_resp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %b want 0", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rsp_valid !== 1'b0 || dp_write !== 1'b0) begin errors++; $display("FAIL reset_valid_write got %b/%b want 0/0", rsp_valid, dp_write); end
        checks++; if (rsp_data !== 32'd0 || rsp_iters !== '0 || dp_addr_a !== 5'd0) begin errors++; $display("FAIL reset_fields data=%h iters=%0d addr_a=%0d want 0", rsp_data, rsp_iters, dp_addr_a); end
        for (int i = 0; i < 32; i++) preload(5'(i), 32'd0);
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        preload(5'd5, 32'h4000_0000);
        preload(5'd6, 32'h0000_1234);
        rst_n = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL release_cmd_ready got %b want 1", cmd_ready); end
    endtask

    task automatic test_add();
        int lat, wrs;
        run_cmd(3'd4, 5'd1, 5'd2, 5'd3, 1'b1, 4'd0, lat, wrs);
        checks++; if (lat != 2) begin errors++; $display("FAIL add_latency got %0d want 2", lat); end
        checks++; if (wrs != 1 || last_wa !== 5'd3) begin errors++; $display("FAIL add_writes got %0d@%0d want 1@3", wrs, last_wa); end
        checks++; if (rsp_data !== 32'd12 || rsp_iters !== 5'd1 || rsp_of !== 1'b0 || rsp_zf !== 1'b0) begin errors++; $display("FAIL add_rsp data=%0d iters=%0d of=%b zf=%b want 12/1/0/0", rsp_data, rsp_iters, rsp_of, rsp_zf); end
        checks++; if (rf[3] !== 32'd12) begin errors++; $display("FAIL add_rf3 got %0d want 12", rf[3]); end
        checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1 || dp_addr_a !== 5'd0 || dp_alu_op !== 3'd0) begin errors++; $display("FAIL add_resp_outputs ready=%b busy=%b addr_a=%0d op=%0d want 0/1/0/0", cmd_ready, busy, dp_addr_a, dp_alu_op); end
        finish_resp();
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL add_back_idle busy=%b ready=%b valid=%b want 0/1/0", busy, cmd_ready, rsp_valid); end
    endtask

    task automatic test_inc_loop();
        int lat, wrs;
        run_cmd(3'd3, 5'd4, 5'd0, 5'd4, 1'b1, 4'd9, lat, wrs);
        checks++; if (lat != 20) begin errors++; $display("FAIL inc_latency got %0d want 20", lat); end
        checks++; if (wrs != 10 || last_wa !== 5'd4) begin errors++; $display("FAIL inc_writes got %0d@%0d want 10@4", wrs, last_wa); end
        checks++; if (rsp_data !== 32'd10 || rsp_iters !== 5'd10) begin errors++; $display("FAIL inc_rsp data=%0d iters=%0d want 10/10", rsp_data, rsp_iters); end
        finish_resp();
    endtask

    task automatic test_no_wb_loop();
        int lat, wrs;
        run_cmd(3'd4, 5'd1, 5'd2, 5'd9, 1'b0, 4'd2, lat, wrs);
        checks++; if (lat != 3) begin errors++; $display("FAIL nowb_latency got %0d want 3", lat); end
        checks++; if (wrs != 0) begin errors++; $display("FAIL nowb_writes got %0d want 0", wrs); end
        checks++; if (rsp_data !== 32'd12 || rsp_iters !== 5'd3) begin errors++; $display("FAIL nowb_rsp data=%0d iters=%0d want 12/3", rsp_data, rsp_iters); end
        finish_resp();
    endtask

    task automatic test_max_iters();
        int lat, wrs;
        run_cmd(3'd4, 5'd1, 5'd2, 5'd12, 1'b0, 4'd15, lat, wrs);
        checks++; if (lat != 16 || rsp_iters !== 5'd16) begin errors++; $display("FAIL max_iters lat=%0d iters=%0d want 16/16", lat, rsp_iters); end
        finish_resp();
    endtask

    task automatic test_overflow_stop();
        int lat, wrs;
        run_cmd(3'd4, 5'd5, 5'd5, 5'd5, 1'b1, 4'd3, lat, wrs);
        checks++; if (lat != 2 || wrs != 1) begin errors++; $display("FAIL of_timing lat=%0d writes=%0d want 2/1", lat, wrs); end
        checks++; if (rsp_data !== 32'h8000_0000 || rsp_iters !== 5'd1 || rsp_of !== 1'b1) begin errors++; $display("FAIL of_rsp data=%h iters=%0d of=%b want 80000000/1/1", rsp_data, rsp_iters, rsp_of); end
        finish_resp();
    endtask

    task automatic test_backpressure();
        int lat, wrs;
        run_cmd(3'd5, 5'd6, 5'd6, 5'd10, 1'b0, 4'd0, lat, wrs);
        checks++; if (lat != 1 || wrs != 0) begin errors++; $display("FAIL bp_timing lat=%0d writes=%0d want 1/0", lat, wrs); end
        checks++; if (rsp_zf !== 1'b1 || rsp_data !== 32'd0) begin errors++; $display("FAIL bp_rsp zf=%b data=%h want 1/0", rsp_zf, rsp_data); end
        // A second command is offered while the response is stalled.
        drive_cmd(3'd4, 5'd1, 5'd2, 5'd11, 1'b1, 4'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_data !== 32'd0) begin errors++; $display("FAIL bp_hold cycle %0d valid=%b ready=%b data=%h want 1/0/0", i, rsp_valid, cmd_ready, rsp_data); end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_pending_idle ready=%b busy=%b want 1/0", cmd_ready, busy); end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_resp(lat);
        checks++; if (lat != 2 || rsp_data !== 32'd12 || last_wa !== 5'd11) begin errors++; $display("FAIL bp_pending_cmd lat=%0d data=%0d wa=%0d want 2/12/11", lat, rsp_data, last_wa); end
        finish_resp();
    endtask

    task automatic test_reset_mid();
        int lat, wrs, w0;
        drive_cmd(3'd3, 5'd8, 5'd0, 5'd8, 1'b1, 4'd5);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (dp_write !== 1'b1) begin errors++; $display("FAIL mid_in_write dp_write=%b want 1", dp_write); end
        w0 = wr_count;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (dp_write !== 1'b0 || busy !== 1'b0 || dp_addr_w !== 5'd0 || cmd_ready !== 1'b0 || rsp_iters !== '0) begin errors++; $display("FAIL mid_async write=%b busy=%b addr_w=%0d ready=%b iters=%0d want all 0", dp_write, busy, dp_addr_w, cmd_ready, rsp_iters); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (wr_count != w0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_aborted writes=%0d valid=%b want 0/0", wr_count - w0, rsp_valid); end
        rst_n = 1'b1;
        #1;
        run_cmd(3'd3, 5'd8, 5'd0, 5'd8, 1'b1, 4'd0, lat, wrs);
        checks++; if (lat != 2 || rsp_data !== 32'd1 || rsp_iters !== 5'd1 || wrs != 1) begin errors++; $display("FAIL mid_next lat=%0d data=%0d iters=%0d writes=%0d want 2/1/1/1", lat, rsp_data, rsp_iters, wrs); end
        finish_resp();
    endtask

    initial begin
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_ra    = '0;
        cmd_rb    = '0;
        cmd_rw    = '0;
        cmd_wb    = 1'b0;
        cmd_rep   = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_inc_loop();
        test_no_wb_loop();
        test_max_iters();
        test_overflow_stop();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter CNT_W, default 4: width of the repeat-count field.
REQ-002 Parameter STOP_ON_OF, default 1: when 1, the repeat loop ends early on overflow.
REQ-003 clk  input  1  single clock; all state updates on the posedge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  controller accepts a command this cycle.
REQ-007 cmd_op  input  3  ALU operation code, passed to the datapath unchanged.
REQ-008 cmd_ra, cmd_rb, cmd_rw  input  5 each  source A, source B and destination register addresses.
REQ-009 cmd_wb  input  1  write result back to cmd_rw on each iteration.
REQ-010 cmd_rep  input  CNT_W  repeat count; the command executes cmd_rep+1 iterations.
REQ-011 dp_addr_a, dp_addr_b, dp_addr_w  output  5 each  register-file read and write addresses.
REQ-012 dp_alu_op  output  3  ALU operation select.
REQ-013 dp_write  output  1  register-file write enable.
REQ-014 dp_f  input  32  ALU result; dp_zf and dp_of  input  1 each  ALU zero and overflow flags.
REQ-015 rsp_valid  output  1  response available; rsp_ready  input  1  response consumed.
REQ-016 rsp_data  output  32  final-iteration result; rsp_zf  output  1  final-iteration zero flag.
REQ-017 rsp_of  output  1  sticky OR of dp_of across all iterations; rsp_iters  output  CNT_W+1  number of iterations executed.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, EXEC, WRITE and RESP.
REQ-020 cmd_ready SHALL be 1 only in IDLE.
- On cmd_valid&cmd_ready, all cmd_* fields are latched.
- Remaining count loads cmd_rep; the iteration counter and sticky OF clear; next state EXEC.
REQ-021 In EXEC and WRITE, the address outputs and dp_alu_op SHALL carry the latched fields.
- In IDLE and RESP they are all 0.
REQ-022 At the end of EXEC, the controller SHALL capture dp_f and dp_zf, OR dp_of into the sticky flag, and increment the iteration counter.
REQ-023 From EXEC, the next state SHALL be WRITE if wb=1; otherwise the FSM takes the loop decision in REQ-025.
REQ-024 In WRITE, dp_write SHALL be 1 for exactly one cycle, with dp_addr_w = latched rw.
- dp_write SHALL be 0 in every other state.
- The written data is the datapath's own dp_f.
REQ-025 Loop decision: if remaining = 0, or (STOP_ON_OF = 1 and dp_of captured this iteration = 1), the next state SHALL be RESP; otherwise remaining decrements and the next state is EXEC.
REQ-026 Because of the WRITE step, a later iteration SHALL read the value written by the previous one (for example, inc r1 in a loop).
REQ-027 Per-iteration latency SHALL be 1 cycle with wb=0 and 2 cycles with wb=1.
- The accept-to-rsp_valid latency is the sum of the per-iteration latencies.
REQ-028 rsp_valid SHALL be 1 only in RESP, with all rsp_* fields stable.
- The FSM leaves RESP for IDLE on the cycle rsp_ready=1; backpressure holds it in RESP indefinitely.
REQ-029 A command offered while not in IDLE SHALL be neither accepted nor lost; it waits for cmd_ready.
REQ-030 rsp_iters SHALL saturate-free count to a maximum of 2^CNT_W.
- It SHALL never wrap.

Reset
REQ-031 Reset=0 SHALL immediately force the FSM to IDLE and clear all outputs to 0, independent of clk.
- Exception: cmd_ready = 1 once Reset=1.
REQ-032 Reset asserted mid-command SHALL abort the command with no further dp_write pulse and no response.
REQ-033 After reset is released, the first posedge SHALL be able to accept a command.

Verification
REQ-034 Reset, then cmd op=4 (add), ra=1 (=5), rb=2 (=7), rw=3, wb=1, rep=0 -> one dp_write pulse at addr 3; rsp_data=12, rsp_iters=1, rsp_of=0; rsp_valid 2 cycles after accept.
REQ-035 cmd op=3 (inc), ra=rw=4 (=0), wb=1, rep=9 -> 10 dp_write pulses; rsp_data=10, rsp_iters=10; rsp_valid 20 cycles after accept.
REQ-036 cmd op=4, ra=rb=rw=5 (=32'h4000_0000), wb=1, rep=3, STOP_ON_OF=1 -> iteration 1 overflows; rsp_iters=1, rsp_of=1, rsp_data=32'h8000_0000.
REQ-037 cmd op=5 (sub), ra=rb=6, wb=0, rep=0 with rsp_ready=0 for 5 cycles -> no dp_write; rsp_zf=1, rsp_data=0; rsp_valid held 5 cycles; cmd_ready=0 throughout.
REQ-038 Reset pulsed low during WRITE of a rep=5 command -> outputs 0 asynchronously; no rsp_valid; the next command executes normally.
